// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and colour type.
// Used by the VGA pin driver, colour control and renderers.
package vga_timing_pkg;

    localparam int CLK_DIV   = 4;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int HCNT_W = 10;
    localparam int VCNT_W = 10;

    typedef logic [11:0] colour_t;

endpackage

// File: rtl/mod_counter.sv
// Enable-gated modulo counter, 0..MAX, with a wrap flag for chaining.
// wrap_o is high on the enabled cycle that returns the count to zero.
module mod_counter #(
    parameter int MAX   = 3,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             at_max;

    assign at_max  = (value_q == MAX_L);
    assign wrap_o  = en_i && at_max;
    assign value_o = value_q;

    always_comb begin
        value_d = value_q;
        if (en_i) begin
            value_d = at_max ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/vga_interface.sv
// VGA timing generator and pin driver: publishes pixel addresses,
// samples the returned colour one pixel later and blanks it.
module vga_interface
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  colour_t     COLOUR_IN,
    output logic [9:0]  horz_address,
    output logic [8:0]  vert_address,
    output logic        FRAME_END,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output colour_t     VGA_COLOUR
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int HT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [HCNT_W-1:0] H_VIS_L = HCNT_W'(H_VISIBLE);
    localparam logic [HCNT_W-1:0] H_SS_L  = HCNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [HCNT_W-1:0] H_SE_L  = HCNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VCNT_W-1:0] V_VIS_L = VCNT_W'(V_VISIBLE);
    localparam logic [VCNT_W-1:0] V_SS_L  = VCNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [VCNT_W-1:0] V_SE_L  = VCNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0]  div_unused;
    logic              tick;
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              h_wrap;
    logic              v_wrap;

    mod_counter #(.MAX(CLK_DIV - 1), .WIDTH(DIV_W)) u_div (
        .clk_i   (CLK),
        .rst_ni  (RESETN),
        .en_i    (1'b1),
        .value_o (div_unused),
        .wrap_o  (tick)
    );

    mod_counter #(.MAX(HT - 1), .WIDTH(HCNT_W)) u_hcnt (
        .clk_i   (CLK),
        .rst_ni  (RESETN),
        .en_i    (tick),
        .value_o (hcount),
        .wrap_o  (h_wrap)
    );

    mod_counter #(.MAX(VT - 1), .WIDTH(VCNT_W)) u_vcnt (
        .clk_i   (CLK),
        .rst_ni  (RESETN),
        .en_i    (h_wrap),
        .value_o (vcount),
        .wrap_o  (v_wrap)
    );

    logic [HCNT_W-1:0] h_next;
    logic [VCNT_W-1:0] v_next;
    logic              visible;

    logic [9:0] horz_q, horz_d;
    logic [8:0] vert_q, vert_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    colour_t    colour_q, colour_d;
    logic       fe_q, fe_d;

    // Addresses track the post-tick counter value so they move with the counters.
    always_comb begin
        h_next = h_wrap ? '0 : hcount + 1'b1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vcount + 1'b1;
        end
        visible  = (hcount < H_VIS_L) && (vcount < V_VIS_L);
        horz_d   = (h_next < H_VIS_L) ? h_next : '0;
        vert_d   = (v_next < V_VIS_L) ? v_next[8:0] : '0;
        hs_d     = !((hcount >= H_SS_L) && (hcount <= H_SE_L));
        vs_d     = !((vcount >= V_SS_L) && (vcount <= V_SE_L));
        colour_d = visible ? COLOUR_IN : 12'h000;
        fe_d     = v_wrap;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            horz_q   <= '0;
            vert_q   <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            colour_q <= '0;
            fe_q     <= 1'b0;
        end else begin
            fe_q <= fe_d;
            if (tick) begin
                horz_q   <= horz_d;
                vert_q   <= vert_d;
                hs_q     <= hs_d;
                vs_q     <= vs_d;
                colour_q <= colour_d;
            end
        end
    end

    assign horz_address = horz_q;
    assign vert_address = vert_q;
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_COLOUR   = colour_q;
    assign FRAME_END    = fe_q;

endmodule
